// File: rtl/vpl_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and width helpers.
// Signed operation is selected at build time with VPL_MULT_SIGNED_EN.
package vpl_mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int prod_w(input int mcand_w, input int mplr_w);
        return mcand_w + mplr_w;
    endfunction

endpackage

// File: rtl/vpl_mult_acc.sv
// Multiplier datapath: M register plus the {carry, high, low} accumulator triple.
// With VPL_MULT_SIGNED_EN the carry acts as a sign bit and the final step subtracts M.
module vpl_mult_acc
    import vpl_mult_pkg::*;
#(
    parameter int MCAND_W = 8,
    parameter int MPLR_W  = 4
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               load,
    input  logic               add,
    input  logic               shift,
`ifdef VPL_MULT_SIGNED_EN
    input  logic               last,
`endif
    input  logic [MCAND_W-1:0] multiplicand,
    input  logic [MPLR_W-1:0]  multiplier,
    output logic [MCAND_W-1:0] high,
    output logic [MPLR_W-1:0]  low
);

    logic [MCAND_W-1:0] m_reg;
    logic               carry;
    logic [MCAND_W:0]   sum;

    // In signed mode carry always mirrors the sign of high between steps, so
    // holding it on a skipped add keeps the arithmetic shift correct.
    always_comb begin
        sum = '0;
`ifdef VPL_MULT_SIGNED_EN
        if (last)
            sum = {high[MCAND_W-1], high} - {m_reg[MCAND_W-1], m_reg};
        else
            sum = {high[MCAND_W-1], high} + {m_reg[MCAND_W-1], m_reg};
`else
        sum = {1'b0, high} + {1'b0, m_reg};
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            carry <= 1'b0;
            high  <= '0;
            low   <= '0;
        end else if (load) begin
            m_reg <= multiplicand;
            carry <= 1'b0;
            high  <= '0;
            low   <= multiplier;
        end else if (add && low[0]) begin
            {carry, high} <= sum;
        end else if (shift) begin
`ifdef VPL_MULT_SIGNED_EN
            {carry, high, low} <= {carry, carry, high, low[MPLR_W-1:1]};
`else
            {carry, high, low} <= {1'b0, carry, high, low[MPLR_W-1:1]};
`endif
        end
    end

endmodule

// File: rtl/vpl_shiftadd_mult.sv
// Sequential shift-and-add multiplier with a constant BIAS added to the final product.
// Define VPL_MULT_SIGNED_EN for two's-complement operands; default build is unsigned.
module vpl_shiftadd_mult
    import vpl_mult_pkg::*;
#(
    parameter int MCAND_W = 8,
    parameter int MPLR_W  = 4,
    parameter int BIAS    = 0,
    localparam int PROD_W = prod_w(MCAND_W, MPLR_W)
) (
    input  logic               clock,
    input  logic               res_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MCAND_W-1:0] multiplicand,
    input  logic [MPLR_W-1:0]  multiplier,
    output logic [PROD_W-1:0]  product,
    output logic               cout,
    output logic               busy,
    output logic               done
);

    localparam int                CNT_W  = $clog2(MPLR_W + 1);
    localparam logic [PROD_W-1:0] BIAS_V = PROD_W'(BIAS);

    logic [1:0]         rst_sync;
    logic               rst_n;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [MCAND_W-1:0] high;
    logic [MPLR_W-1:0]  low;
    logic [PROD_W:0]    biased;
    logic               acc_load;
    logic               acc_add;
    logic               acc_shift;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n     = rst_sync[1];
    assign acc_load  = (state == IDLE)  && start && !abort;
    assign acc_add   = (state == ADD)   && !abort;
    assign acc_shift = (state == SHIFT) && !abort;
    assign biased    = {1'b0, high, low} + {1'b0, BIAS_V};

    vpl_mult_acc #(
        .MCAND_W (MCAND_W),
        .MPLR_W  (MPLR_W)
    ) u_acc (
        .clock        (clock),
        .rst_n        (rst_n),
        .load         (acc_load),
        .add          (acc_add),
        .shift        (acc_shift),
`ifdef VPL_MULT_SIGNED_EN
        .last         (cnt == CNT_W'(1)),
`endif
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .high         (high),
        .low          (low)
    );

    // product/cout only move in DONE, so an aborted run leaves the last result intact.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            product <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= ADD;
                            cnt   <= CNT_W'(MPLR_W);
                            busy  <= 1'b1;
                        end
                    end
                    ADD: begin
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ADD;
                        end
                    end
                    DONE: begin
                        product <= biased[PROD_W-1:0];
                        cout    <= biased[PROD_W];
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vpl_shiftadd_mult.sv
// Directed bench for vpl_shiftadd_mult: plain and BIAS=0xAAA instances share stimulus.
// Vector set follows VPL_MULT_SIGNED_EN when that macro is defined for the build.
module tb_vpl_shiftadd_mult;

    logic        clock = 1'b0;
    logic        res_n;
    logic        start;
    logic        abort;
    logic [7:0]  multiplicand;
    logic [3:0]  multiplier;
    logic [11:0] product, product_b;
    logic        cout, cout_b;
    logic        busy, busy_b;
    logic        done, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    vpl_shiftadd_mult dut (
        .clock        (clock),
        .res_n        (res_n),
        .start        (start),
        .abort        (abort),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .cout         (cout),
        .busy         (busy),
        .done         (done)
    );

    vpl_shiftadd_mult #(.BIAS(32'hAAA)) dut_bias (
        .clock        (clock),
        .res_n        (res_n),
        .start        (start),
        .abort        (abort),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product_b),
        .cout         (cout_b),
        .busy         (busy_b),
        .done         (done_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One full multiply: capture, latency count to done, result check, pulse width check.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [3:0] b,
                                 input logic [11:0] exp_p, input logic [11:0] exp_pb,
                                 input logic exp_cb);
        int lat;
        @(negedge clock);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        checkOutput({tag, "_busy"}, busy, 1);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!done && lat < 40);
        checkOutput({tag, "_lat"}, lat, 9);
        checkOutput({tag, "_prod"}, product, exp_p);
        checkOutput({tag, "_cout"}, cout, 0);
        checkOutput({tag, "_prod_bias"}, product_b, exp_pb);
        checkOutput({tag, "_cout_bias"}, cout_b, exp_cb);
        @(posedge clock);
        #1 checkOutput({tag, "_pulse"}, done, 0);
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock);
            #1;
            if (done || done_b) n++;
        end
    endtask

    initial begin
        int first, second, nd, busy10;
        logic [11:0] p1, p2;

        res_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_prod", product, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_prod_bias", product_b, 0);
        @(negedge clock) res_n = 1'b1;
        repeat (4) @(posedge clock);

        applyStimulus("m7x3", 8'h07, 4'h3, 12'h015, 12'hABF, 1'b0);
        applyStimulus("m5Ax6", 8'h5A, 4'h6, 12'h21C, 12'hCC6, 1'b0);
`ifdef VPL_MULT_SIGNED_EN
        applyStimulus("s_min", 8'h80, 4'h8, 12'h400, 12'hEAA, 1'b0);
        applyStimulus("s_neg1", 8'h7F, 4'hF, 12'hF81, 12'hA2B, 1'b1);
`else
        applyStimulus("u_max", 8'hFF, 4'hF, 12'hEF1, 12'h99B, 1'b1);
        applyStimulus("u_zero", 8'h00, 4'hF, 12'h000, 12'hAAA, 1'b0);
`endif

        // start held high; operands changed while busy must only affect the second run
        @(negedge clock);
        multiplicand = 8'h07;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(posedge clock);
        #1;
        multiplicand = 8'h5A;
        multiplier   = 4'h6;
        first = 0; second = 0; nd = 0; busy10 = 0; p1 = '0; p2 = '0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                nd++;
                if (first == 0) begin
                    first = k;
                    p1 = product;
                end else if (second == 0) begin
                    second = k;
                    p2 = product;
                end
            end
            if (k == 10) begin
                busy10 = busy;
                start  = 1'b0;
            end
        end
        checkOutput("hold_first_done", first, 9);
        checkOutput("hold_second_done", second, 19);
        checkOutput("hold_done_count", nd, 2);
        checkOutput("hold_recapture", busy10, 1);
        checkOutput("hold_prod1", p1, 12'h015);
        checkOutput("hold_prod2", p2, 12'h21C);

        // abort in the 4th cycle after capture
        @(negedge clock);
        multiplicand = 8'hFF;
        multiplier   = 4'hF;
        start        = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        countDone(15, nd);
        checkOutput("abort_no_done", nd, 0);
        checkOutput("abort_prod", product, 12'h21C);
        checkOutput("abort_prod_bias", product_b, 12'hCC6);

        // abort together with start in IDLE
        @(negedge clock);
        multiplicand = 8'h07;
        multiplier   = 4'h3;
        start        = 1'b1;
        abort        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_busy", busy, 0);
        countDone(15, nd);
        checkOutput("abort_start_no_done", nd, 0);
        checkOutput("abort_start_prod", product, 12'h21C);

        // reset pulse mid-operation
        @(negedge clock);
        multiplicand = 8'h07;
        multiplier   = 4'h3;
        start        = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 res_n = 1'b0;
        #1;
        checkOutput("midrst_prod", product, 0);
        checkOutput("midrst_prod_bias", product_b, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) res_n = 1'b1;
        countDone(15, nd);
        checkOutput("midrst_no_done", nd, 0);
        applyStimulus("post_rst", 8'h5A, 4'h6, 12'h21C, 12'hCC6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vpl_shiftadd_mult.md
VPL_SHIFTADD_MULT -- requirements
Module: vpl_shiftadd_mult

Interface
REQ-001 SHALL have parameter MCAND_W, default 8, multiplicand width (2..32).
REQ-002 SHALL have parameter MPLR_W, default 4, multiplier width and iteration count (2..16).
REQ-003 SHALL have parameter BIAS, default 0, constant added modulo 2^(MCAND_W+MPLR_W) to the final product.
REQ-004 SHALL be single-clock with asynchronous active-low reset.
REQ-005 Ports SHALL be:
- clock  in  1  rising-edge clock
- res_n  in  1  async active-low reset
- start  in  1  request, sampled in IDLE only
- abort  in  1  sync cancel, returns to IDLE
- multiplicand  in  MCAND_W  operand A
- multiplier  in  MPLR_W  operand B
- product  out  MCAND_W+MPLR_W  registered result (+BIAS)
- cout  out  1  carry out of the BIAS addition
- busy  out  1  high in ADD/SHIFT
- done  out  1  one-cycle completion pulse

Function
REQ-006 SHALL implement FSM states IDLE, ADD, SHIFT, DONE.
REQ-007 In IDLE with start=1, SHALL capture multiplicand into the M register and multiplier into the low half, clear the high half and carry, load iteration counter = MPLR_W, then enter ADD.
REQ-008 ADD SHALL add M to the high half when the low-half LSB=1, storing the sum's carry; otherwise hold.
REQ-009 SHIFT SHALL right-shift {carry, high, low} by one, decrement the counter, and go to DONE at count 0, else ADD.
REQ-010 The high half SHALL be MCAND_W bits wide and the adder MCAND_W+1 bits wide; no intermediate overflow SHALL be lost.
REQ-011 DONE SHALL register product = {high, low} + BIAS, set cout to the carry of that addition, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-012 Latency SHALL be exactly 2*MPLR_W+1 cycles from the start-capture edge to the edge at which done rises.
REQ-013 product and cout SHALL hold their values until the next DONE; they are not updated mid-operation.
REQ-014 start SHALL be ignored in ADD, SHIFT and DONE; a new start is accepted at the earliest in the cycle after DONE.
REQ-015 abort=1 in any state SHALL force IDLE on the next edge, with busy=0, no done pulse, and product unchanged; abort wins over a simultaneous start.
REQ-016 Operands SHALL be sampled only at capture; input changes during busy SHALL have no effect.

Reset
REQ-017 res_n=0 SHALL asynchronously force IDLE and clear the M register, high half, low half, carry, counter, product, cout, busy and done.
REQ-018 Reset asserted mid-operation SHALL discard that operation; no done pulse SHALL follow.
REQ-019 Reset release SHALL be synchronised to clock before it is used by the FSM.

Configuration
REQ-020 Macro VPL_MULT_SIGNED_EN SHALL select signed operation; when it is defined:
- both operands are two's complement;
- the carry bit is replaced by sign extension of the adder (arithmetic shift);
- the final iteration subtracts M when the multiplier MSB=1;
- product is the signed result.
REQ-021 When VPL_MULT_SIGNED_EN is undefined, operation SHALL be unsigned only, with no subtract logic present.

Structure
REQ-022 The FSM state enum, the state-width constant and the PROD_W = MCAND_W+MPLR_W helper SHALL reside in the shared package vpl_mult_pkg.
REQ-023 The datapath register triple {carry, high, low} with load and shift controls SHALL be the single sub-module vpl_mult_acc; the FSM and counter remain in the top level.

Verification
REQ-024 Defaults, unsigned: A=0xFF, B=0xF, start pulse -> done exactly 9 cycles after capture, product=0xEF1, cout=0.
REQ-025 Defaults with BIAS=0xAAA: A=0x07, B=0x3 -> product=0xABF, cout=0; A=0xFF, B=0xF -> product=0x99B, cout=1.
REQ-026 VPL_MULT_SIGNED_EN defined: A=0x80 (-128), B=0x8 (-8) -> product=0x400; A=0x7F, B=0xF (-1) -> product=0xF81.
REQ-027 start held high through an operation -> exactly one done pulse, then a second capture in the cycle after DONE; operand changes during busy do not alter product.
REQ-028 abort asserted in the 4th cycle after capture -> IDLE next edge, no done pulse, previous product retained; abort together with start in IDLE -> no capture.
REQ-029 res_n pulsed low mid-operation -> all outputs 0 immediately; a following start yields a correct result with normal latency.
